// File: rtl/sigmoid_pkg.sv
// Shared Q4.12 constants, sigmoid PWL tables and stage payloads.
// Also imported by the tanh stage, which builds on ONE_Q412 and HALF_Q412.
package sigmoid_pkg;

  localparam int unsigned X_W    = 16;
  localparam int unsigned Y_W    = 16;
  localparam int unsigned MAG_W  = 15;
  localparam int unsigned SEG_W  = 3;
  localparam int unsigned FRAC_W = 12;
  localparam int unsigned P_W    = 13;
  localparam int unsigned M_W    = 10;
  localparam int unsigned PROD_W = 24;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned NSEG   = 8;

  localparam int unsigned ONE_Q412  = 4096;
  localparam int unsigned HALF_Q412 = 2048;

  localparam logic [X_W-1:0] X_MIN_Q412 = 16'h8000;

  typedef logic signed [X_W-1:0] q412_t;

  // Segment base values and slopes; C[i+1] = C[i] + M[i] keeps the curve continuous.
  localparam logic [P_W-1:0] C_TAB [NSEG] = '{
    13'd2048, 13'd2995, 13'd3608, 13'd3902,
    13'd4022, 13'd4069, 13'd4086, 13'd4092
  };
  localparam logic [M_W-1:0] M_TAB [NSEG] = '{
    10'd947, 10'd613, 10'd294, 10'd120,
    10'd47,  10'd17,  10'd6,   10'd3
  };

  typedef struct packed {
    logic              sign;
    logic [SEG_W-1:0]  seg;
    logic [FRAC_W-1:0] frac;
  } s1_t;

  typedef struct packed {
    logic           sign;
    logic [P_W-1:0] p;
  } s2_t;

endpackage

// File: rtl/sigmoid_pwl_seg.sv
// Combinational PWL segment evaluation: p = C[seg] + round(M[seg]*frac / 4096).
module sigmoid_pwl_seg
  import sigmoid_pkg::*;
(
  input  logic [SEG_W-1:0]  seg,
  input  logic [FRAC_W-1:0] frac,
  output logic [P_W-1:0]    p_c
);

  logic [PROD_W-1:0] prod;
  logic [P_W-1:0]    slope_term;

  always_comb begin
    prod       = PROD_W'(M_TAB[seg]) * PROD_W'(frac);
    slope_term = P_W'((prod + PROD_W'(HALF_Q412)) >> FRAC_W);
    p_c        = C_TAB[seg] + slope_term;
  end

endmodule

// File: rtl/sigmoid_pwl_pipe.sv
// Three-stage piecewise-linear sigmoid with valid/ready flow control.
// Define SIGMOID_SAT_CNT_EN to add the sat_cnt saturating-sample counter port.
module sigmoid_pwl_pipe
  import sigmoid_pkg::*;
#(
  parameter int unsigned SAT_SEG = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [X_W-1:0]   in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Y_W-1:0]   out_y
`ifdef SIGMOID_SAT_CNT_EN
  ,
  output logic [CNT_W-1:0] sat_cnt
`endif
);

  if (SAT_SEG > NSEG) begin : g_sat_seg_chk
    $error("SAT_SEG must not exceed the number of segments");
  end

  logic           adv;
  logic           s1_valid;
  logic           s2_valid;
  s1_t            s1_d;
  s1_t            s1_q;
  s2_t            s2_d;
  s2_t            s2_q;
  logic [P_W-1:0] p_c;
  logic [Y_W-1:0] y_d;
  logic [MAG_W-1:0] mag;
  q412_t          x_s;

  // Whole pipe advances together; a stalled output freezes every stage.
  always_comb begin
    adv      = !out_valid || out_ready;
    in_ready = adv;
  end

  // S1 decode: magnitude with the most-negative code clamped to the largest positive.
  always_comb begin
    x_s  = q412_t'(in_x);
    mag  = MAG_W'(in_x);
    if (in_x == X_MIN_Q412) begin
      mag = '1;
    end else if (x_s < 0) begin
      mag = MAG_W'(-x_s);
    end
    s1_d      = '0;
    s1_d.sign = in_x[X_W-1];
    s1_d.seg  = mag[FRAC_W +: SEG_W];
    s1_d.frac = mag[FRAC_W-1:0];
  end

  sigmoid_pwl_seg u_seg (
    .seg  (s1_q.seg),
    .frac (s1_q.frac),
    .p_c  (p_c)
  );

  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.p    = p_c;
    y_d       = s2_q.sign ? (Y_W'(ONE_Q412) - Y_W'(s2_q.p)) : Y_W'(s2_q.p);
  end

  // Payload registers only load behind a valid bit; bubbles move through as bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      out_y     <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (in_valid) s1_q  <= s1_d;
      if (s1_valid) s2_q  <= s2_d;
      if (s2_valid) out_y <= y_d;
    end
  end

`ifdef SIGMOID_SAT_CNT_EN
  logic sat_hit;

  always_comb begin
    sat_hit = in_valid && adv && (32'(s1_d.seg) >= SAT_SEG);
  end

  // Counts accepted far-tail samples; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (sat_hit && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sigmoid_pwl_pipe.sv
// Scoreboard bench for sigmoid_pwl_pipe: directed cases, stall, reset and full input sweep.
module tb_sigmoid_pwl_pipe;

  // Chord interpolation sags below the concave curve by up to ~50 LSB mid-segment.
  localparam int ERR_TOL = 64;
  localparam int C_T [8] = '{2048, 2995, 3608, 3902, 4022, 4069, 4086, 4092};
  localparam int M_T [8] = '{947, 613, 294, 120, 47, 17, 6, 3};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_x;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_y;

  typedef struct {
    logic [15:0] x;
    int          y;
    bit          lat;
    bit          sweep;
    bit          first;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   sat_exp = 0;
  int   all_exp = 0;
  bit   lat_mode = 1'b0;
  bit   sweep_mode = 1'b0;
  bit   first_mode = 1'b0;
  int   prev_y = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

`ifdef SIGMOID_SAT_CNT_EN
  logic [15:0] sat_cnt;
  logic        in_ready_all;
  logic        out_valid_all;
  logic [15:0] out_y_all;
  logic [15:0] sat_cnt_all;

  sigmoid_pwl_pipe #(.SAT_SEG(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .sat_cnt(sat_cnt)
  );

  // Every sample counts here, so the full sweep drives this counter into saturation.
  sigmoid_pwl_pipe #(.SAT_SEG(0)) dut_all (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_all), .in_x(in_x),
    .out_valid(out_valid_all), .out_ready(out_ready), .out_y(out_y_all), .sat_cnt(sat_cnt_all)
  );
`else
  sigmoid_pwl_pipe #(.SAT_SEG(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
  );
`endif

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mag_of(input logic [15:0] x);
    int xi;
    int a;
    xi = int'($signed(x));
    a  = (xi < 0) ? -xi : xi;
    if (a > 32767) a = 32767;
    return a;
  endfunction

  function automatic int model(input logic [15:0] x);
    int a;
    int s;
    int p;
    a = mag_of(x);
    s = a / 4096;
    p = C_T[s] + (M_T[s] * (a % 4096) + 2048) / 4096;
    return (int'($signed(x)) < 0) ? 4096 - p : p;
  endfunction

  // Monitor: handshakes are judged at the falling edge, before the edge that completes them.
  always @(negedge clk) begin
    exp_t e;
    real  xr;
    int   ref_y;
    int   err;
    if (rst) begin
      q.delete();
      sat_exp = 0;
      all_exp = 0;
    end else begin
      if (in_valid && in_ready) begin
        e.x     = in_x;
        e.y     = model(in_x);
        e.lat   = lat_mode;
        e.sweep = sweep_mode;
        e.first = first_mode;
        e.cyc   = cyc;
        q.push_back(e);
        if (mag_of(in_x) / 4096 >= 4 && sat_exp < 65535) sat_exp++;
        if (all_exp < 65535) all_exp++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", out_valid, 0);
        end else begin
          e = q.pop_front();
          check("out_y", out_y, e.y);
`ifdef SIGMOID_SAT_CNT_EN
          check("all_out_y", out_y_all, e.y);
          check("all_out_valid", out_valid_all, 1);
          check("all_in_ready", in_ready_all, 1);
`endif
          if (e.lat) check("latency", cyc - e.cyc, 3);
          if (e.sweep) begin
            if (!e.first) check("monotonic", (int'(out_y) >= prev_y), 1);
            prev_y = int'(out_y);
            xr     = real'(int'($signed(e.x))) / 4096.0;
            ref_y  = $rtoi(4096.0 / (1.0 + $exp(-xr)) + 0.5);
            err    = int'(out_y) - ref_y;
            if (err < 0) err = -err;
            check("sigmoid_err_within_tol", (err <= ERR_TOL), 1);
            if (e.x != 16'h0000) check("range_1_4095", (out_y >= 16'd1 && out_y <= 16'd4095), 1);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] x);
    int k;
    k        = 0;
    in_valid = 1'b1;
    in_x     = x;
    #1;
    while (!in_ready && k < 50) begin
      tick();
      #1;
      k++;
    end
    if (!in_ready) check("send_timeout_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int k;
    k = 0;
    while (q.size() != 0 && k < limit) begin
      tick();
      k++;
    end
    check("drain_queue_empty", q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d pending, expected 0", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = 16'h0000;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y", out_y, 0);
`ifdef SIGMOID_SAT_CNT_EN
    check("rst_sat_cnt", sat_cnt, 0);
`endif
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", in_ready, 1);

`ifdef SIGMOID_SAT_CNT_EN
    for (int i = 0; i < 10; i++) send(16'h5000);
    for (int i = 0; i < 3; i++) send(16'h1000);
    wait_drain(20);
    check("sat_cnt_ten", sat_cnt, 10);
`endif

    // Back-to-back directed values, each exactly three cycles behind its acceptance.
    lat_mode = 1'b1;
    send(16'h0000);
    send(16'h1000);
    send(16'hF000);
    send(16'h0800);
    lat_mode = 1'b0;
    wait_drain(20);

    // Extremes including the clamp path, separated by a bubble.
    lat_mode = 1'b1;
    send(16'h7FFF);
    tick();
    send(16'h8000);
    lat_mode = 1'b0;
    wait_drain(20);

    // Three samples in flight against a five-cycle downstream stall.
    out_ready = 1'b0;
    send(16'h0400);
    send(16'hFC00);
    send(16'h2800);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_y_held", out_y, q[0].y);
      tick();
    end
    out_ready = 1'b1;
    wait_drain(20);

    // Reset with one sample presented at the output and one behind it.
    send(16'h1800);
    send(16'hE800);
    tick();
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_out_y", out_y, 0);
    tick();
    rst = 1'b0;
    #1;
    check("in_ready_after_mid_rst", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("no_stale_output", out_valid, 0);
    end

    // Full input sweep in ascending signed order.
    sweep_mode = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      first_mode = (i == 0);
      send(16'(i + 32768));
    end
    sweep_mode = 1'b0;
    first_mode = 1'b0;
    wait_drain(20);

`ifdef SIGMOID_SAT_CNT_EN
    check("sat_cnt_model", sat_cnt, sat_exp);
    check("sat_cnt_all_full", sat_cnt_all, 16'hFFFF);
    for (int i = 0; i < 3; i++) send(16'h0000);
    wait_drain(20);
    check("sat_cnt_all_no_wrap", sat_cnt_all, 16'hFFFF);
    check("sat_cnt_all_model", sat_cnt_all, all_exp);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
